dvd_motion_scheduler: RTL and testbench

//  Frame-rate motion controller for the one-pixel bouncing-logo screensaver.

---
 rtl/dvd_motion_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_dvd_motion_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvd_motion_scheduler.sv
// dvd_motion_scheduler
//
// Frame-rate motion controller for the one-pixel bouncing-logo screensaver.
// A rising edge of vsync marks a frame start. The logo cell position steps
// once every (speed+1) frames. Each axis bounces independently between 0 and
// its MAX. Registered bounce/corner pulses are generated. A palette index
// advances on every bounce and selects the logo colour.
//
// Optional feature macro: CORNER_FLASH_EN
//   When defined, a corner loads a flash counter with FLASH_FR. The counter
//   counts down once per frame, and the colour is inverted while it is non-zero.
//
// Ports
//   clk       in   1    pixel clock
//   rst_n     in   1    asynchronous active-low reset
//   vsync     in   1    vsync from the sync generator (frame start = rising edge)
//   speed     in   3    step every speed+1 frames
//   pause     in   1    freeze motion and frame divider
//   restart   in   1    synchronous reload of the initial state
//   dir_init  in   2    {dir_x, dir_y} loaded on restart, 1 = increasing
//   dvd_x     out  X_W  logo column
//   dvd_y     out  Y_W  logo row
//   colour    out  6    {R[1:0],G[1:0],B[1:0]}
//   bounce    out  1    one-cycle pulse, at least one axis reversed
//   corner    out  1    one-cycle pulse, both axes reversed

module dvd_motion_scheduler #(
    parameter int         X_W      = 5,
    parameter int         Y_W      = 4,
    parameter int         X_MAX    = 19,
    parameter int         Y_MAX    = 14,
    parameter int         X_INIT   = 0,
    parameter int         Y_INIT   = 1,
    parameter logic [3:0] FLASH_FR = 4'd15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           vsync,
    input  logic [2:0]     speed,
    input  logic           pause,
    input  logic           restart,
    input  logic [1:0]     dir_init,
    output logic [X_W-1:0] dvd_x,
    output logic [Y_W-1:0] dvd_y,
    output logic [5:0]     colour,
    output logic           bounce,
    output logic           corner
);

    localparam logic [X_W-1:0] X_MAX_V  = X_MAX[X_W-1:0];
    localparam logic [Y_W-1:0] Y_MAX_V  = Y_MAX[Y_W-1:0];
    localparam logic [X_W-1:0] X_INIT_V = X_INIT[X_W-1:0];
    localparam logic [Y_W-1:0] Y_INIT_V = Y_INIT[Y_W-1:0];

    logic       vsync_q;
    logic       dir_x;
    logic       dir_y;
    logic [2:0] fcnt;
    logic [2:0] pal_idx;
    logic       tick;
    logic       step;

    logic [X_W-1:0] x_nxt;
    logic [Y_W-1:0] y_nxt;
    logic           dx_nxt;
    logic           dy_nxt;
    logic           rev_x;
    logic           rev_y;

    // vsync_q resets high, so a vsync already high at reset release
    // does not produce a tick.
    assign tick = vsync & ~vsync_q;

    // A restart in the tick cycle wins. That frame then produces no step.
    assign step = tick & ~pause & ~restart & (fcnt >= speed);

    // Next position per axis. A reversal uses up the step without moving.
    always_comb begin
        x_nxt  = dvd_x;
        dx_nxt = dir_x;
        rev_x  = 1'b0;
        if (dir_x) begin
            if (dvd_x == X_MAX_V) begin
                dx_nxt = 1'b0;
                rev_x  = 1'b1;
            end else begin
                x_nxt = dvd_x + X_W'(1);
            end
        end else begin
            if (dvd_x == '0) begin
                dx_nxt = 1'b1;
                rev_x  = 1'b1;
            end else begin
                x_nxt = dvd_x - X_W'(1);
            end
        end
    end

    always_comb begin
        y_nxt  = dvd_y;
        dy_nxt = dir_y;
        rev_y  = 1'b0;
        if (dir_y) begin
            if (dvd_y == Y_MAX_V) begin
                dy_nxt = 1'b0;
                rev_y  = 1'b1;
            end else begin
                y_nxt = dvd_y + Y_W'(1);
            end
        end else begin
            if (dvd_y == '0) begin
                dy_nxt = 1'b1;
                rev_y  = 1'b1;
            end else begin
                y_nxt = dvd_y - Y_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b1;
            dvd_x   <= X_INIT_V;
            dvd_y   <= Y_INIT_V;
            dir_x   <= 1'b1;
            dir_y   <= 1'b1;
            fcnt    <= 3'd0;
            pal_idx <= 3'd0;
            bounce  <= 1'b0;
            corner  <= 1'b0;
        end else begin
            // The edge detector keeps running through pause and restart.
            vsync_q <= vsync;
            if (restart) begin
                dvd_x   <= X_INIT_V;
                dvd_y   <= Y_INIT_V;
                dir_x   <= dir_init[1];
                dir_y   <= dir_init[0];
                fcnt    <= 3'd0;
                pal_idx <= 3'd0;
                bounce  <= 1'b0;
                corner  <= 1'b0;
            end else begin
                bounce <= step & (rev_x | rev_y);
                corner <= step & rev_x & rev_y;
                // A >= compare (rather than ==) copes with speed being
                // lowered below the current count.
                if (tick && !pause) begin
                    fcnt <= (fcnt >= speed) ? 3'd0 : fcnt + 3'd1;
                end
                if (step) begin
                    dvd_x <= x_nxt;
                    dvd_y <= y_nxt;
                    dir_x <= dx_nxt;
                    dir_y <= dy_nxt;
                    // A corner counts as one bounce for the palette.
                    if (rev_x || rev_y) begin
                        pal_idx <= pal_idx + 3'd1;
                    end
                end
            end
        end
    end

    function automatic logic [5:0] pal_lut(input logic [2:0] idx);
        logic [5:0] c;
        case (idx)
            3'd0:    c = 6'b110000;
            3'd1:    c = 6'b111100;
            3'd2:    c = 6'b001100;
            3'd3:    c = 6'b001111;
            3'd4:    c = 6'b000011;
            3'd5:    c = 6'b110011;
            3'd6:    c = 6'b111111;
            default: c = 6'b100110;
        endcase
        return c;
    endfunction

`ifdef CORNER_FLASH_EN
    logic [3:0] flash;

    // A corner happens on a tick. Reloading takes priority over the
    // countdown, so a corner during a flash restarts it at FLASH_FR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash <= 4'd0;
        end else if (restart) begin
            flash <= 4'd0;
        end else if (step && rev_x && rev_y) begin
            flash <= FLASH_FR;
        end else if (tick && flash != 4'd0) begin
            flash <= flash - 4'd1;
        end
    end

    assign colour = (flash != 4'd0) ? ~pal_lut(pal_idx) : pal_lut(pal_idx);
`else
    // FLASH_FR has no effect without the flash counter.
    logic unused_flash_fr;
    assign unused_flash_fr = ^FLASH_FR;

    assign colour = pal_lut(pal_idx);
`endif

endmodule

// File: tb/tb_dvd_motion_scheduler.sv
// Testbench for dvd_motion_scheduler.
// u_dut1 uses the default parameters.
// u_dut2 uses Y_INIT=0 and FLASH_FR=3, for the corner and flash sequences.
// Frames are table driven. Expected outputs are queued when a vsync edge is
// driven, then popped and compared after the clock edge that applies the step.

module tb_dvd_motion_scheduler;

    localparam int OW = 17;  // {x[4:0], y[3:0], colour[5:0], bounce, corner}

`ifdef CORNER_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       vsync;
    logic [2:0] speed;
    logic       pause;
    logic       restart;
    logic [1:0] dir_init;
    logic       restart2;
    logic [1:0] dir_init2;

    logic [4:0] dvd_x1, dvd_x2;
    logic [3:0] dvd_y1, dvd_y2;
    logic [5:0] colour1, colour2;
    logic       bounce1, bounce2, corner1, corner2;

    logic [OW-1:0] out1, out2;
    assign out1 = {dvd_x1, dvd_y1, colour1, bounce1, corner1};
    assign out2 = {dvd_x2, dvd_y2, colour2, bounce2, corner2};

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] exp2_q[$];

    logic [5:0] pal_tab [8] = '{6'b110000, 6'b111100, 6'b001100, 6'b001111,
                                6'b000011, 6'b110011, 6'b111111, 6'b100110};

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int spd;
        bit pse;
        int x;
        int y;
        int pal;
        bit b;
        bit c;
    } vec_t;

    vec_t vt [48];
    int   nv;

    dvd_motion_scheduler u_dut1 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .speed(speed), .pause(pause),
        .restart(restart), .dir_init(dir_init),
        .dvd_x(dvd_x1), .dvd_y(dvd_y1), .colour(colour1),
        .bounce(bounce1), .corner(corner1)
    );

    dvd_motion_scheduler #(.Y_INIT(0), .FLASH_FR(4'd3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .speed(speed), .pause(pause),
        .restart(restart2), .dir_init(dir_init2),
        .dvd_x(dvd_x2), .dvd_y(dvd_y2), .colour(colour2),
        .bounce(bounce2), .corner(corner2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    function automatic logic [OW-1:0] mk(input int x, input int y, input int pal,
                                         input bit b, input bit c, input bit inv);
        logic [5:0] col;
        logic [4:0] xv;
        logic [3:0] yv;
        logic [2:0] pv;
        xv  = x[4:0];
        yv  = y[3:0];
        pv  = pal[2:0];
        col = inv ? ~pal_tab[pv] : pal_tab[pv];
        return {xv, yv, col, b, c};
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act,
                         input logic [OW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got x=%0d y=%0d col=%b b=%b c=%b, want x=%0d y=%0d col=%b b=%b c=%b",
                     name, act[16:12], act[11:8], act[7:2], act[1], act[0],
                     exp[16:12], exp[11:8], exp[7:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_pulse(input string name, input logic [1:0] act);
        tests_run++;
        if (act !== 2'b00) begin
            tests_failed++;
            $display("FAIL %s: got bounce/corner=%b, want 00", name, act);
        end
    endtask

    // ---------------- driver ----------------
    // One frame: raise vsync, compare after the stepping edge, confirm the
    // pulses drop one cycle later, then drop vsync again.
    task automatic frame(input bit chk1, input bit chk2);
        logic [OW-1:0] e;
        vsync = 1'b1;
        @(posedge clk); #1;
        restart  = 1'b0;
        restart2 = 1'b0;
        if (chk1) begin
            if (exp_q.size() == 0) begin
                tests_run++; tests_failed++;
                $display("FAIL dut1_queue: got empty queue, want an entry");
            end else begin
                e = exp_q.pop_front();
                check("dut1_frame", out1, e);
            end
        end
        if (chk2) begin
            if (exp2_q.size() == 0) begin
                tests_run++; tests_failed++;
                $display("FAIL dut2_queue: got empty queue, want an entry");
            end else begin
                e = exp2_q.pop_front();
                check("dut2_frame", out2, e);
            end
        end
        @(posedge clk); #1;
        if (chk1) check_pulse("dut1_pulse_clear", {bounce1, corner1});
        if (chk2) check_pulse("dut2_pulse_clear", {bounce2, corner2});
        vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic add(input int spd, input bit pse, input int x, input int y,
                       input int pal, input bit b, input bit c);
        vt[nv] = '{spd, pse, x, y, pal, b, c};
        nv++;
    endtask

    // ---------------- test ----------------
    initial begin
        // Frame vectors for the default instance (start (0,1), dir 11).
        nv = 0;
        for (int k = 1; k <= 13; k++) add(0, 0, k, 1 + k, 0, 0, 0);
        add(0, 0, 14, 14, 1, 1, 0);                            // row reverses at max
        for (int k = 15; k <= 19; k++) add(0, 0, k, 28 - k, 1, 0, 0);
        add(0, 0, 19, 8, 2, 1, 0);                             // column reverses at max
        add(0, 0, 18, 7, 2, 0, 0);
        add(2, 0, 18, 7, 2, 0, 0);                             // fcnt 0->1
        add(2, 0, 18, 7, 2, 0, 0);                             // fcnt 1->2
        add(2, 0, 17, 6, 2, 0, 0);                             // step
        add(2, 0, 17, 6, 2, 0, 0);                             // fcnt 0->1
        for (int k = 0; k < 5; k++) add(2, 1, 17, 6, 2, 0, 0); // paused, fcnt held
        add(2, 0, 17, 6, 2, 0, 0);                             // fcnt 1->2
        add(2, 0, 16, 5, 2, 0, 0);                             // step
        add(2, 0, 16, 5, 2, 0, 0);
        add(2, 0, 16, 5, 2, 0, 0);
        add(2, 0, 15, 4, 2, 0, 0);

        // Reset held with vsync high.
        rst_n = 1'b0; vsync = 1'b1; speed = 3'd0; pause = 1'b0;
        restart = 1'b0; dir_init = 2'b11; restart2 = 1'b0; dir_init2 = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_dut1", out1, mk(0, 1, 0, 0, 0, 0));
        check("reset_dut2", out2, mk(0, 0, 0, 0, 0, 0));
        // vsync already high at release must not count as a frame start.
        repeat (4) @(posedge clk);
        #1;
        check("no_tick_after_reset", out1, mk(0, 1, 0, 0, 0, 0));
        vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Table-driven frames.
        for (int i = 0; i < nv; i++) begin
            speed = vt[i].spd[2:0];
            pause = vt[i].pse;
            exp_q.push_back(mk(vt[i].x, vt[i].y, vt[i].pal, vt[i].b, vt[i].c, 1'b0));
            frame(1'b1, 1'b0);
        end

        // Corner at (0,0) on the Y_INIT=0 instance, then the flash window.
        speed = 3'd0; pause = 1'b0;
        dir_init2 = 2'b00; restart2 = 1'b1;
        @(posedge clk); #1;
        restart2 = 1'b0;
        check("dut2_restart", out2, mk(0, 0, 0, 0, 0, 0));
        exp2_q.push_back(mk(0, 0, 1, 1, 1, FLASH_ON));
        exp2_q.push_back(mk(1, 1, 1, 0, 0, FLASH_ON));
        exp2_q.push_back(mk(2, 2, 1, 0, 0, FLASH_ON));
        exp2_q.push_back(mk(3, 3, 1, 0, 0, 1'b0));
        exp2_q.push_back(mk(4, 4, 1, 0, 0, 1'b0));
        for (int i = 0; i < 5; i++) frame(1'b0, 1'b1);

        // Restart in the tick cycle wins: init state, no step, no bounce.
        dir_init = 2'b10; restart = 1'b1;
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
        frame(1'b1, 1'b0);
        // speed 7: fcnt climbs 0..5 without stepping.
        speed = 3'd7;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
            frame(1'b1, 1'b0);
        end
        // Lowering speed below fcnt steps on the very next frame.
        speed = 3'd0;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        frame(1'b1, 1'b0);
        exp_q.push_back(mk(2, 0, 1, 1, 0, 0));                 // row reverses at 0
        frame(1'b1, 1'b0);

        if (exp_q.size() != 0 || exp2_q.size() != 0) begin
            tests_run++; tests_failed++;
            $display("FAIL queue_drain: got %0d/%0d left, want 0/0",
                     exp_q.size(), exp2_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
